ev_motor_pwm_driver: RTL and testbench

// Motor-side receiver for the 8-bit motor speed command produced by the EV motor control block.

---
 rtl/ev_motor_pwm_driver.sv | 130 +++++++++++++
 tb/tb_ev_motor_pwm_driver.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ev_motor_pwm_driver.sv
// Motor-side speed command receiver: slew-limited duty ramp driving a registered PWM gate output.
// E-stop overrides everything except reset and latches FAULT until explicitly cleared.
module ev_motor_pwm_driver #(
    parameter int unsigned RAMP_DIV  = 16,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] cmd_speed,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       estop,
    input  logic       fault_clr,
    output logic       pwm_out,
    output logic [7:0] duty,
    output logic [2:0] state,
    output logic       at_target,
    output logic       fault
);

    localparam int unsigned      RampW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RampW-1:0] RampLast = RampW'(RAMP_DIV - 1);
    localparam logic [7:0]       StepMax  = 8'(RAMP_STEP);
    localparam logic [7:0]       PwmLast  = 8'd254;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRampUp = 3'd1,
        StRampDn = 3'd2,
        StRun    = 3'd3,
        StFault  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       target_q, target_d;
    logic [7:0]       duty_q, duty_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [RampW-1:0] ramp_cnt_q, ramp_cnt_d;
    logic             pwm_q, pwm_d;

    logic [7:0] gap;
    logic [7:0] step;
    logic       boundary;
    logic       accept;

    assign cmd_ready = ena && (state_q != StFault);
    assign accept    = cmd_valid && cmd_ready;
    assign boundary  = ena && (pwm_cnt_q == PwmLast);

    // Clamping the step to the remaining gap keeps the ramp from overshooting or wrapping.
    assign gap  = (target_q > duty_q) ? (target_q - duty_q) : (duty_q - target_q);
    assign step = (gap < StepMax) ? gap : StepMax;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        duty_d     = duty_q;
        pwm_cnt_d  = pwm_cnt_q;
        ramp_cnt_d = ramp_cnt_q;
        pwm_d      = pwm_q;

        if (estop) begin
            state_d    = StFault;
            target_d   = 8'd0;
            duty_d     = 8'd0;
            pwm_cnt_d  = 8'd0;
            ramp_cnt_d = '0;
            pwm_d      = 1'b0;
        end else if (ena) begin
            if (state_q == StFault) begin
                if (fault_clr) begin
                    state_d = StIdle;
                end
            end else begin
                if (duty_q < target_q) begin
                    state_d = StRampUp;
                end else if (duty_q > target_q) begin
                    state_d = StRampDn;
                end else if (duty_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StRun;
                end

                pwm_d     = (pwm_cnt_q < duty_q);
                pwm_cnt_d = boundary ? 8'd0 : (pwm_cnt_q + 8'd1);

                if (boundary) begin
                    if (ramp_cnt_q == RampLast) begin
                        ramp_cnt_d = '0;
                        duty_d     = (target_q > duty_q) ? (duty_q + step) : (duty_q - step);
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + RampW'(1);
                    end
                end

                // The step above deliberately sees the pre-accept target.
                if (accept) begin
                    target_d = cmd_speed;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            target_q   <= 8'd0;
            duty_q     <= 8'd0;
            pwm_cnt_q  <= 8'd0;
            ramp_cnt_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            duty_q     <= duty_d;
            pwm_cnt_q  <= pwm_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_out   = pwm_q;
    assign duty      = duty_q;
    assign state     = state_q;
    assign at_target = (duty_q == target_q);
    assign fault     = (state_q == StFault);

endmodule

// File: tb/tb_ev_motor_pwm_driver.sv
// Bench for ev_motor_pwm_driver: two configurations share one stimulus stream and are checked
// every cycle against a behavioural model, plus a vector table and directed ramp/fault sequences.
module tb_ev_motor_pwm_driver;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] cmd_speed;
    logic       cmd_valid;
    logic       estop;
    logic       fault_clr;

    logic       ready_w [2];
    logic       pwm_w   [2];
    logic [7:0] duty_w  [2];
    logic [2:0] state_w [2];
    logic       at_w    [2];
    logic       fault_w [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model state, index 0: RAMP_DIV=1/RAMP_STEP=16, index 1: RAMP_DIV=4/RAMP_STEP=255
    int div_p  [2] = '{1, 4};
    int step_p [2] = '{16, 255};
    int m_state[2];
    int m_target[2];
    int m_duty [2];
    int m_cnt  [2];
    int m_per  [2];
    int m_pwm  [2];

    ev_motor_pwm_driver #(.RAMP_DIV(1), .RAMP_STEP(16)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_speed (cmd_speed),
        .cmd_valid (cmd_valid),
        .cmd_ready (ready_w[0]),
        .estop     (estop),
        .fault_clr (fault_clr),
        .pwm_out   (pwm_w[0]),
        .duty      (duty_w[0]),
        .state     (state_w[0]),
        .at_target (at_w[0]),
        .fault     (fault_w[0])
    );

    ev_motor_pwm_driver #(.RAMP_DIV(4), .RAMP_STEP(255)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_speed (cmd_speed),
        .cmd_valid (cmd_valid),
        .cmd_ready (ready_w[1]),
        .estop     (estop),
        .fault_clr (fault_clr),
        .pwm_out   (pwm_w[1]),
        .duty      (duty_w[1]),
        .state     (state_w[1]),
        .at_target (at_w[1]),
        .fault     (fault_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pack(int r, int f, int a, int s, int p, int d);
        return (r << 14) | (f << 13) | (a << 12) | (s << 9) | (p << 8) | d;
    endfunction

    function automatic int act_pack(int i);
        return pack(int'(ready_w[i]), int'(fault_w[i]), int'(at_w[i]), int'(state_w[i]),
                    int'(pwm_w[i]), int'(duty_w[i]));
    endfunction

    function automatic int exp_pack(int i);
        int r;
        r = (ena && m_state[i] != 4) ? 1 : 0;
        return pack(r, (m_state[i] == 4) ? 1 : 0, (m_duty[i] == m_target[i]) ? 1 : 0,
                    m_state[i], m_pwm[i], m_duty[i]);
    endfunction

    // One clock of the behavioural model, from the inputs present at the edge.
    task automatic model_tick(input int i);
        int ns;
        int g;
        int st;
        if (!rst_n || estop) begin
            m_state[i]  = rst_n ? 4 : 0;
            m_target[i] = 0;
            m_duty[i]   = 0;
            m_cnt[i]    = 0;
            m_per[i]    = 0;
            m_pwm[i]    = 0;
        end else if (ena) begin
            if (m_state[i] == 4) begin
                if (fault_clr) m_state[i] = 0;
            end else begin
                if (m_duty[i] < m_target[i])      ns = 1;
                else if (m_duty[i] > m_target[i]) ns = 2;
                else                              ns = (m_duty[i] == 0) ? 0 : 3;
                m_pwm[i] = (m_cnt[i] < m_duty[i]) ? 1 : 0;
                if (m_cnt[i] == 254) begin
                    m_per[i]++;
                    if (m_per[i] == div_p[i]) begin
                        m_per[i] = 0;
                        g  = m_target[i] - m_duty[i];
                        st = (g < 0) ? -g : g;
                        if (st > step_p[i]) st = step_p[i];
                        m_duty[i] += (g > 0) ? st : -st;
                    end
                end
                m_cnt[i] = (m_cnt[i] + 1) % 255;
                if (cmd_valid) m_target[i] = int'(cmd_speed);
                m_state[i] = ns;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick(0);
        model_tick(1);
        cyc++;
        #1;
        check("model_a", act_pack(0), exp_pack(0));
        check("model_b", act_pack(1), exp_pack(1));
    endtask

    task automatic wait_duty(input int i, input int limit);
        logic [7:0] prev;
        int n;
        prev = duty_w[i];
        n = 0;
        while (duty_w[i] == prev && n < limit) begin
            tick();
            n++;
        end
        check("wait_duty_change", int'(duty_w[i] != prev), 1);
    endtask

    typedef struct {
        logic       rst_n;
        logic       ena;
        logic       estop;
        logic       fclr;
        logic       valid;
        logic [7:0] speed;
        int         e_state;
        int         e_duty;
        int         e_pwm;
        int         e_ready;
        int         e_at;
        int         e_fault;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int t0;
        int t_last;
        int hi;
        int bad;
        int n;
        int dn_seq[5];

        rst_n = 1'b0; ena = 1'b1; estop = 1'b0; fault_clr = 1'b0;
        cmd_valid = 1'b0; cmd_speed = 8'h00;

        //           rst ena est clr vld speed   st duty pwm rdy at flt
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 0, 1, 1, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 0, 1, 1, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 0, 0, 0, 1, 0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0, 0, 1, 0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 4, 0, 0, 0, 1, 1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4, 0, 0, 0, 1, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 4, 0, 0, 0, 1, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4, 0, 0, 0, 1, 1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 0, 1, 1, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 4, 0, 0, 0, 1, 1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 0, 1, 1, 0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h30, 0, 0, 0, 0, 1, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 0, 1, 1, 0};

        for (int r = 0; r < 13; r++) begin
            rst_n = tbl[r].rst_n; ena = tbl[r].ena; estop = tbl[r].estop;
            fault_clr = tbl[r].fclr; cmd_valid = tbl[r].valid; cmd_speed = tbl[r].speed;
            tick();
            for (int i = 0; i < 2; i++) begin
                check($sformatf("vec%0d_dut%0d", r, i), act_pack(i),
                      pack(tbl[r].e_ready, tbl[r].e_fault, tbl[r].e_at, tbl[r].e_state,
                           tbl[r].e_pwm, tbl[r].e_duty));
            end
        end
        fault_clr = 1'b0; cmd_valid = 1'b0; ena = 1'b1; estop = 1'b0;

        // Ramp up to 0x40 in steps of 16, one step per 255-clock period
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        t0 = cyc;
        cmd_valid = 1'b1; cmd_speed = 8'h40; tick(); cmd_valid = 1'b0;
        t_last = t0;
        for (int j = 1; j <= 4; j++) begin
            wait_duty(0, 300);
            check("t2_duty", int'(duty_w[0]), 16 * j);
            check("t2_period", cyc - t_last, 255);
            t_last = cyc;
            if (j == 1) begin
                tick();
                check("t2_state_up", int'(state_w[0]), 1);
            end
        end
        tick();
        check("t2_state_run", int'(state_w[0]), 3);
        hi = 0;
        repeat (255) begin tick(); hi += int'(pwm_w[0]); end
        check("t2_pwm_high", hi, 64);

        // Non-multiple target, then ramp back down to zero
        cmd_valid = 1'b1; cmd_speed = 8'h4A; tick(); cmd_valid = 1'b0;
        wait_duty(0, 300);
        check("t3_no_overshoot", int'(duty_w[0]), 8'h4A);
        tick();
        check("t3_state_run", int'(state_w[0]), 3);
        cmd_valid = 1'b1; cmd_speed = 8'h00; tick(); cmd_valid = 1'b0; tick();
        check("t3_state_dn", int'(state_w[0]), 2);
        dn_seq = '{8'h3A, 8'h2A, 8'h1A, 8'h0A, 8'h00};
        for (int j = 0; j < 5; j++) begin
            wait_duty(0, 300);
            check("t3_duty_dn", int'(duty_w[0]), dn_seq[j]);
        end
        tick();
        check("t3_state_idle", int'(state_w[0]), 0);

        // Accept on a boundary edge: that step still uses the old target (0)
        n = 0;
        while (m_cnt[0] != 254 && n < 300) begin tick(); n++; end
        cmd_valid = 1'b1; cmd_speed = 8'h20; tick(); cmd_valid = 1'b0;
        check("t5_boundary_old_target", int'(duty_w[0]), 0);
        t_last = cyc;
        wait_duty(0, 300);
        check("t5_next_step", int'(duty_w[0]), 16);
        check("t5_period", cyc - t_last, 255);

        // E-stop mid-ramp at duty 32 heading for 0x80
        cmd_valid = 1'b1; cmd_speed = 8'h80; tick(); cmd_valid = 1'b0;
        wait_duty(0, 300);
        check("t4_duty32", int'(duty_w[0]), 32);
        tick();
        check("t4_pre_pwm", int'(pwm_w[0]), 1);
        estop = 1'b1; tick();
        check("t4_duty", int'(duty_w[0]), 0);
        check("t4_pwm", int'(pwm_w[0]), 0);
        check("t4_state", int'(state_w[0]), 4);
        check("t4_ready", int'(ready_w[0]), 0);
        fault_clr = 1'b1; tick();
        check("t4_clr_ignored", int'(state_w[0]), 4);
        estop = 1'b0; tick();
        check("t4_cleared", int'(state_w[0]), 0);
        fault_clr = 1'b0;

        // ena gating on the RAMP_DIV=4 / RAMP_STEP=255 instance
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        t0 = cyc;
        cmd_valid = 1'b1; cmd_speed = 8'hFF; tick(); cmd_valid = 1'b0;
        repeat (99) tick();
        ena = 1'b0;
        bad = 0;
        repeat (500) begin
            tick();
            if (duty_w[1] != 8'd0 || state_w[1] != 3'd1 || pwm_w[1] != 1'b0) bad++;
        end
        check("t6_ena_hold", bad, 0);
        ena = 1'b1;
        wait_duty(1, 1200);
        check("t6_jump", int'(duty_w[1]), 255);
        check("t6_jump_time", cyc - t0, 1020 + 500);
        tick();
        hi = 0;
        repeat (255) begin tick(); hi += int'(pwm_w[1]); end
        check("t6_pwm_const_high", hi, 255);

        // Randomised traffic against the model
        for (int k = 0; k < 6000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (estop) estop = ($urandom_range(0, 3) != 0);
            else       estop = ($urandom_range(0, 149) == 0);
            fault_clr = ($urandom_range(0, 7) == 0);
            ena       = ($urandom_range(0, 9) != 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       cmd_speed = 8'h00;
                1:       cmd_speed = 8'hFF;
                default: cmd_speed = 8'($urandom_range(0, 255));
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
